// File: rtl/train_sequencer.sv
// train_sequencer: epoch controller gating samples into the layer pipeline and driving the shared mode line.
// Latency: sample path is a zero-cycle pass-through; mode/epoch/state are registered.
// Backpressure: source ready follows layer ready, masked when not issuing or when DEPTH samples are in flight.
// Build option: define TRAIN_SEQ_TEST_PHASE_EN to add the test (inference) phase after each training phase.
module train_sequencer #(
  parameter int NP    = 8,
  parameter int WF    = 5,
  parameter int NS    = 16,
  parameter int NT    = 4,
  parameter int NE    = 4,
  parameter int DEPTH = 8
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic                      iStart,
  input  logic                      iValid_AM_Sample,
  output logic                      oReady_AM_Sample,
  input  logic [NP*WF-1:0]          iData_AM_Sample,
  output logic                      oValid_BM_Sample,
  input  logic                      iReady_BM_Sample,
  output logic [NP*WF-1:0]          oData_BM_Sample,
  input  logic                      iValid_AS_Done,
  output logic                      oReady_AS_Done,
  output logic                      oMode,
  output logic [$clog2(NE+1)-1:0]   oEpoch,
  output logic                      oBusy,
  output logic                      oDone,
  output logic                      oErr
);

  localparam int LMAX = (NS > NT) ? NS : NT;
  localparam int ISW  = $clog2(LMAX + 1);
  localparam int IFW  = $clog2(DEPTH + 1);
  localparam int EPW  = $clog2(NE + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TRAIN   = 3'd1,
    S_DRAIN_T = 3'd2,
    S_TEST    = 3'd3,
    S_DRAIN_I = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [ISW-1:0]   issued, issued_nxt, limit;
  logic [IFW-1:0]   inflight, inflight_nxt;
  logic [EPW-1:0]   epoch_nxt;
  logic             mode_nxt, err_nxt;
  logic             en, issue, done;

  // Gate the handshake: only while issuing, below the phase quota, and with room in the pipeline.
  always_comb begin
    limit = ISW'(NS);
`ifdef TRAIN_SEQ_TEST_PHASE_EN
    if (state == S_TEST) limit = ISW'(NT);
`endif
    en = (state == S_TRAIN || state == S_TEST) && (issued < limit) && (inflight < IFW'(DEPTH));
    oValid_BM_Sample = iValid_AM_Sample & en;
    oReady_AM_Sample = iReady_BM_Sample & en;
    oData_BM_Sample  = iData_AM_Sample;
    oReady_AS_Done   = 1'b1;
    oBusy            = (state != S_IDLE);
    oDone            = (state == S_FIN);
    issue            = oValid_BM_Sample & iReady_BM_Sample;
    done             = iValid_AS_Done;
  end

  // In-flight accounting; a completion with nothing outstanding is flagged, never underflows.
  always_comb begin
    inflight_nxt = inflight;
    err_nxt      = oErr;
    if (issue && !done) begin
      inflight_nxt = inflight + 1'b1;
    end else if (done && !issue) begin
      if (inflight == '0) err_nxt = 1'b1;
      else                inflight_nxt = inflight - 1'b1;
    end
  end

  // Phase sequencing: mode only flips at phase boundaries, which are reached with an empty pipeline.
  always_comb begin
    state_nxt  = state;
    epoch_nxt  = oEpoch;
    mode_nxt   = oMode;
    issued_nxt = issue ? issued + 1'b1 : issued;
    case (state)
      S_IDLE: begin
        if (iStart) begin
          state_nxt  = S_TRAIN;
          mode_nxt   = 1'b1;
          epoch_nxt  = '0;
          issued_nxt = '0;
        end
      end
      S_TRAIN: begin
        if (issued_nxt == ISW'(NS)) state_nxt = S_DRAIN_T;
      end
      S_DRAIN_T: begin
        if (inflight_nxt == '0) begin
          issued_nxt = '0;
`ifdef TRAIN_SEQ_TEST_PHASE_EN
          state_nxt  = S_TEST;
          mode_nxt   = 1'b0;
`else
          epoch_nxt  = oEpoch + 1'b1;
          state_nxt  = (oEpoch == EPW'(NE - 1)) ? S_FIN : S_TRAIN;
`endif
        end
      end
`ifdef TRAIN_SEQ_TEST_PHASE_EN
      S_TEST: begin
        if (issued_nxt == ISW'(NT)) state_nxt = S_DRAIN_I;
      end
      S_DRAIN_I: begin
        if (inflight_nxt == '0) begin
          issued_nxt = '0;
          epoch_nxt  = oEpoch + 1'b1;
          if (oEpoch == EPW'(NE - 1)) begin
            state_nxt = S_FIN;
          end else begin
            state_nxt = S_TRAIN;
            mode_nxt  = 1'b1;
          end
        end
      end
`endif
      S_FIN: begin
        state_nxt = S_IDLE;
        mode_nxt  = 1'b0;
      end
      default: begin
        state_nxt = S_IDLE;
        mode_nxt  = 1'b0;
      end
    endcase
  end

  // State and counter registers; reset discards any in-flight accounting.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= S_IDLE;
      issued   <= '0;
      inflight <= '0;
      oEpoch   <= '0;
      oMode    <= 1'b0;
      oErr     <= 1'b0;
    end else begin
      state    <= state_nxt;
      issued   <= issued_nxt;
      inflight <= inflight_nxt;
      oEpoch   <= epoch_nxt;
      oMode    <= mode_nxt;
      oErr     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_train_sequencer.sv
// Testbench for train_sequencer: random and directed stimulus against a phase-list reference model.
// Latency: outputs checked every cycle at the falling edge against the model.
// Backpressure: source valid / layer ready driven randomly or held, completions from a delay queue.
module tb_train_sequencer;

  localparam int NP    = 8;
  localparam int WF    = 5;
  localparam int NS    = 4;
  localparam int NT    = 2;
  localparam int NE    = 3;
  localparam int DEPTH = 3;
  localparam int DW    = NP * WF;
  localparam int EPW   = $clog2(NE + 1);
`ifdef TRAIN_SEQ_TEST_PHASE_EN
  localparam int PPE   = 2;
`else
  localparam int PPE   = 1;
`endif

  logic           clk = 1'b0;
  logic           rst, start, vin, rdy_am, vout, rin, done_in, rdy_done;
  logic [DW-1:0]  din, dout;
  logic           omode, obusy, odone, oerr;
  logic [EPW-1:0] oepoch;

  train_sequencer #(.NP(NP), .WF(WF), .NS(NS), .NT(NT), .NE(NE), .DEPTH(DEPTH)) dut (
    .iCLK(clk), .iRST(rst), .iStart(start),
    .iValid_AM_Sample(vin), .oReady_AM_Sample(rdy_am), .iData_AM_Sample(din),
    .oValid_BM_Sample(vout), .iReady_BM_Sample(rin), .oData_BM_Sample(dout),
    .iValid_AS_Done(done_in), .oReady_AS_Done(rdy_done),
    .oMode(omode), .oEpoch(oepoch), .oBusy(obusy), .oDone(odone), .oErr(oerr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model: a run is a list of phases (train, then test if enabled) per epoch
  bit m_run, m_fin, m_err, m_mode;
  int m_pi, m_cnt, m_inf, m_epoch;

  int q_pend[$];
  int done_dly  = 0;
  bit rand_dly  = 0;
  bit chk_en    = 1;
  bit rec       = 0;
  bit last_iss  = 0;
  int n_iss     = 0;
  int n_done    = 0;
  int last_ep   = 0;
  bit dut_modes[$];
  int dut_eps[$];

  function automatic int lim(input int pi);
`ifdef TRAIN_SEQ_TEST_PHASE_EN
    return (pi == 0) ? NS : NT;
`else
    return NS + 0 * pi;
`endif
  endfunction

  function automatic bit model_en();
    return m_run && !m_fin && (m_cnt < lim(m_pi)) && (m_inf < DEPTH);
  endfunction

  task automatic model_clock(input bit v, input bit r, input bit st, input bit rs, input bit dn);
    bit iss, was_drain;
    if (rs) begin
      m_run = 0; m_fin = 0; m_err = 0; m_mode = 0;
      m_pi = 0; m_cnt = 0; m_inf = 0; m_epoch = 0;
      return;
    end
    iss       = v && r && model_en();
    was_drain = m_run && !m_fin && (m_cnt == lim(m_pi));
    if (iss && !dn) m_inf++;
    else if (dn && !iss) begin
      if (m_inf == 0) m_err = 1;
      else            m_inf--;
    end
    if (m_fin) begin
      m_fin = 0; m_run = 0; m_mode = 0;
    end else if (!m_run) begin
      if (st) begin
        m_run = 1; m_pi = 0; m_cnt = 0; m_epoch = 0; m_mode = 1;
      end
    end else begin
      if (iss) m_cnt++;
      if (was_drain && m_inf == 0) begin
        if (m_pi == PPE - 1) begin
          m_epoch++;
          if (m_epoch == NE) m_fin = 1;
          else begin m_pi = 0; m_cnt = 0; m_mode = 1; end
        end else begin
          m_pi++; m_cnt = 0; m_mode = 0;
        end
      end
    end
  endtask

  // one clock cycle: drive after the rising edge, check at the falling edge, advance the model
  task automatic step(input bit v, input bit r, input bit st, input bit rs, input bit extra);
    bit dn, en;
    logic [6+EPW:0] exp_ctl, act_ctl;
    dn = extra;
    if (!extra && q_pend.size() > 0 && q_pend[0] <= cyc) begin
      dn = 1;
      void'(q_pend.pop_front());
    end
    vin = v; rin = r; start = st; rst = rs; done_in = dn;
    din = DW'({$urandom(), $urandom()});
    @(negedge clk);
    en      = model_en();
    exp_ctl = {v & en, r & en, m_mode, EPW'(m_epoch), m_run, m_fin, m_err, 1'b1};
    act_ctl = {vout, rdy_am, omode, oepoch, obusy, odone, oerr, rdy_done};
    if (chk_en) begin
      n_checks++;
      if (act_ctl !== exp_ctl) begin
        n_fail++;
        $display("FAIL ctl cyc=%0d got=%b want=%b (vld,rdy,mode,epoch,busy,done,err,done_rdy)", cyc, act_ctl, exp_ctl);
      end
      n_checks++;
      if (dout !== din) begin
        n_fail++;
        $display("FAIL data cyc=%0d got=%h want=%h", cyc, dout, din);
      end
    end
    last_iss = vout & rin;
    if (rec) begin
      if (last_iss) begin n_iss++; dut_modes.push_back(omode); end
      if (odone) n_done++;
      if (int'(oepoch) != last_ep) begin last_ep = int'(oepoch); dut_eps.push_back(last_ep); end
    end
    @(posedge clk);
    if (v && r && en && !rs) begin
      if (rand_dly)          q_pend.push_back(cyc + int'($urandom_range(1, 4)));
      else if (done_dly > 0) q_pend.push_back(cyc + done_dly);
    end
    model_clock(v, r, st, rs, dn);
    cyc++;
    #1;
  endtask

  task automatic do_reset(input bit flush);
    if (flush) q_pend.delete();
    step(0, 0, 0, 1, 0);
  endtask

  task automatic clear_rec();
    n_iss = 0; n_done = 0; last_ep = 0;
    dut_modes.delete(); dut_eps.delete();
  endtask

  task automatic test_reset();
    chk_en = 0;
    do_reset(1);
    chk_en = 1;
    do_reset(1);
    step(1, 1, 0, 0, 0);
    n_checks++;
    if ({omode, oepoch, obusy, odone, oerr, rdy_done, vout, rdy_am} !== {3'b000, {EPW{1'b0}}, 5'b00100}) begin
      n_fail++;
      $display("FAIL reset_vals got mode=%b ep=%0d busy=%b done=%b err=%b drdy=%b vld=%b rdy=%b",
               omode, oepoch, obusy, odone, oerr, rdy_done, vout, rdy_am);
    end
  endtask

  task automatic test_basic_run();
    int k, exp_iss, idx;
    bit ok;
    do_reset(1);
    done_dly = 2; rand_dly = 0;
    clear_rec(); rec = 1;
    step(1, 1, 1, 0, 0);
    for (k = 0; k < 400 && n_done == 0; k++) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    rec = 0;
    n_checks++;
    if (k >= 400) begin n_fail++; $display("FAIL basic_timeout got cycles=%0d want <400", k); end
    exp_iss = (PPE == 2) ? (NS + NT) * NE : NS * NE;
    n_checks++;
    if (n_iss != exp_iss) begin n_fail++; $display("FAIL basic_issues got=%0d want=%0d", n_iss, exp_iss); end
    ok = (dut_modes.size() == exp_iss);
    for (int e = 0; e < NE && ok; e++) begin
      for (int i = 0; i < NS; i++) begin
        idx = e * (exp_iss / NE) + i;
        if (dut_modes[idx] !== 1'b1) ok = 0;
      end
      if (PPE == 2)
        for (int i = 0; i < NT; i++) begin
          idx = e * (exp_iss / NE) + NS + i;
          if (dut_modes[idx] !== 1'b0) ok = 0;
        end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_mode_seq got=%p want %0d train then %0d test per epoch", dut_modes, NS, (PPE == 2) ? NT : 0); end
    ok = (dut_eps.size() == NE);
    for (int i = 0; i < dut_eps.size() && ok; i++) if (dut_eps[i] != i + 1) ok = 0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_epoch_seq got=%p want 1..%0d", dut_eps, NE); end
    n_checks++;
    if (n_done != 1) begin n_fail++; $display("FAIL basic_done_pulses got=%0d want=1", n_done); end
    n_checks++;
    if (omode !== 1'b0 || obusy !== 1'b0) begin n_fail++; $display("FAIL basic_end_idle got mode=%b busy=%b want 0 0", omode, obusy); end
  endtask

  task automatic test_depth_cap();
    int cnt;
    do_reset(1);
    done_dly = 0; rand_dly = 0;
    step(1, 1, 1, 0, 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin step(1, 1, 0, 0, 0); cnt += int'(last_iss); end
    n_checks++;
    if (cnt != DEPTH) begin n_fail++; $display("FAIL cap_issues got=%0d want=%0d", cnt, DEPTH); end
    n_checks++;
    if (rdy_am !== 1'b0) begin n_fail++; $display("FAIL cap_ready got=%b want=0", rdy_am); end
    step(1, 1, 0, 0, 1);
    n_checks++;
    if (last_iss !== 1'b0) begin n_fail++; $display("FAIL cap_same_cycle got=%b want=0", last_iss); end
    step(1, 1, 0, 0, 0);
    n_checks++;
    if (last_iss !== 1'b1) begin n_fail++; $display("FAIL cap_next_issue got=%b want=1", last_iss); end
    step(1, 1, 0, 0, 0);
    n_checks++;
    if (last_iss !== 1'b0) begin n_fail++; $display("FAIL cap_single got=%b want=0", last_iss); end
    for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic test_simultaneous();
    int k;
    bit hit;
    do_reset(1);
    done_dly = 1; rand_dly = 0;
    step(1, 1, 1, 0, 0);
    hit = 0;
    for (k = 1; k <= 40 && !hit; k++) begin
      step(1, 1, 0, 0, 0);
      hit = (PPE == 2) ? (omode === 1'b0) : (oepoch === EPW'(1));
    end
    n_checks++;
    if (k - 1 != NS + 1) begin n_fail++; $display("FAIL simul_phase_edge got=%0d want=%0d cycles", k - 1, NS + 1); end
    n_checks++;
    if (oerr !== 1'b0) begin n_fail++; $display("FAIL simul_err got=%b want=0", oerr); end
  endtask

  task automatic test_spurious();
    do_reset(1);
    step(0, 0, 0, 0, 1);
    n_checks++;
    if (oerr !== 1'b1) begin n_fail++; $display("FAIL spur_set got=%b want=1", oerr); end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    n_checks++;
    if (oerr !== 1'b1) begin n_fail++; $display("FAIL spur_sticky got=%b want=1", oerr); end
    do_reset(1);
    n_checks++;
    if (oerr !== 1'b0) begin n_fail++; $display("FAIL spur_clear got=%b want=0", oerr); end
  endtask

  task automatic test_mid_reset();
    int k;
    do_reset(1);
    done_dly = 0; rand_dly = 0;
    step(1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    do_reset(0);
    n_checks++;
    if ({obusy, omode, oepoch} !== {2'b00, {EPW{1'b0}}}) begin
      n_fail++; $display("FAIL midrst_state got busy=%b mode=%b ep=%0d want 0 0 0", obusy, omode, oepoch);
    end
    done_dly = 2;
    clear_rec(); rec = 1;
    step(1, 1, 1, 0, 1);
    n_checks++;
    if (oerr !== 1'b1) begin n_fail++; $display("FAIL midrst_late_done got=%b want=1", oerr); end
    for (k = 0; k < 400 && n_done == 0; k++) step(1, 1, 0, 0, 0);
    rec = 0;
    n_checks++;
    if (n_done != 1 || oepoch !== EPW'(NE)) begin
      n_fail++; $display("FAIL midrst_rerun got done=%0d ep=%0d want 1 %0d", n_done, oepoch, NE);
    end
  endtask

  task automatic test_random();
    int k;
    rand_dly = 1;
    for (int run = 0; run < 3; run++) begin
      do_reset(1);
      clear_rec(); rec = 1;
      step(1, 1, 1, 0, 0);
      for (k = 0; k < 2000 && n_done == 0; k++)
        step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 0, 0);
      rec = 0;
      n_checks++;
      if (k >= 2000) begin n_fail++; $display("FAIL random_timeout run=%0d got cycles=%0d", run, k); end
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    end
    rand_dly = 0;
  endtask

  initial begin
    vin = 0; rin = 0; start = 0; rst = 1; done_in = 0; din = '0;
    m_run = 0; m_fin = 0; m_err = 0; m_mode = 0; m_pi = 0; m_cnt = 0; m_inf = 0; m_epoch = 0;
    @(posedge clk); #1;
    test_reset();
    test_basic_run();
    test_depth_cap();
    test_simultaneous();
    test_spurious();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
